// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, stall, flush and bubble insertion.
// SKID=1 adds a second entry so o_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int              DW          = 128,
    parameter int              SKID        = 1,
    parameter int              ZERO_BUBBLE = 1,
    parameter logic [DW-1:0]   RST_VAL     = '0,
    parameter int              CNTW        = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [DW-1:0]   i_data,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [DW-1:0]   o_data,
    output logic [1:0]      o_occ,
    output logic [CNTW-1:0] o_xfer_cnt,
    output logic [CNTW-1:0] o_kill_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_valid;
    logic            w_ready;
    logic [1:0]      w_occ;
    logic [DW-1:0]   r_main;
    logic [CNTW-1:0] r_xfer_cnt;
    logic [CNTW-1:0] r_kill_cnt;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {{(CNTW-1){1'b0}}, b};
        return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
    endfunction

    assign w_in_fire  = i_valid & w_ready & ~i_flush;
    assign w_out_fire = w_valid & i_ready & ~i_stall & ~i_flush;

    if (SKID != 0) begin : g_skid
        state_t        r_state;
        state_t        w_state_nxt;
        logic          r_rdy;
        logic          w_ld_main_in;
        logic          w_ld_main_skid;
        logic          w_ld_skid;
        logic [DW-1:0] r_skid;

        always_comb begin
            w_state_nxt    = r_state;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
            if (i_flush) begin
                w_state_nxt = ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            w_state_nxt  = ST_BUSY;
                            w_ld_main_in = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (w_in_fire && w_out_fire) begin
                            w_ld_main_in = 1'b1;
                        end else if (w_in_fire) begin
                            w_state_nxt = ST_FULL;
                            w_ld_skid   = 1'b1;
                        end else if (w_out_fire) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_out_fire) begin
                            w_state_nxt    = ST_BUSY;
                            w_ld_main_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_EMPTY;
                endcase
            end
        end

        // o_ready is decoded from the next state so it leaves a flop directly
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_state <= ST_EMPTY;
                r_rdy   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rdy   <= (w_state_nxt != ST_FULL);
            end
        end

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_main <= RST_VAL;
            end else if (w_ld_main_in) begin
                r_main <= i_data;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
        end

        always_ff @(posedge i_clk) begin
            if (w_ld_skid) begin
                r_skid <= i_data;
            end
        end

        assign w_valid = (r_state != ST_EMPTY);
        assign w_ready = r_rdy;
        assign w_occ   = (r_state == ST_FULL) ? 2'd2 :
                         (r_state == ST_BUSY) ? 2'd1 : 2'd0;
    end else begin : g_single
        logic r_vld;
        logic r_alive;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_vld   <= 1'b0;
                r_alive <= 1'b0;
            end else begin
                r_alive <= 1'b1;
                if (i_flush) begin
                    r_vld <= 1'b0;
                end else if (w_in_fire) begin
                    r_vld <= 1'b1;
                end else if (w_out_fire) begin
                    r_vld <= 1'b0;
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_main <= RST_VAL;
            end else if (w_in_fire) begin
                r_main <= i_data;
            end
        end

        // r_alive keeps o_ready low through reset and the cycle of release
        assign w_valid = r_vld;
        assign w_ready = r_alive & (~r_vld | (i_ready & ~i_stall));
        assign w_occ   = {1'b0, r_vld};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_xfer_cnt <= '0;
            r_kill_cnt <= '0;
        end else begin
            r_xfer_cnt <= r_xfer_cnt + {{(CNTW-1){1'b0}}, w_out_fire};
            if (i_flush) begin
                r_kill_cnt <= sat_add(r_kill_cnt, w_occ);
            end
        end
    end

    assign o_valid    = w_valid;
    assign o_ready    = w_ready;
    assign o_occ      = w_occ;
    assign o_data     = ((ZERO_BUBBLE != 0) && !w_valid) ? RST_VAL : r_main;
    assign o_xfer_cnt = r_xfer_cnt;
    assign o_kill_cnt = r_kill_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: lane 0 is the skid build, lane 1 the single-entry
// build with a 4-bit counter; each lane has a queue-based reference model.
module tb_pipe_stage_reg;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int            SK  = (g == 0) ? 1 : 0;
        localparam int            CW  = (g == 0) ? 16 : 4;
        localparam logic [DW-1:0] BUB = (g == 0) ? 32'h0 : 32'h5A5A_0000;

        logic          rst_n   = 1'b1;
        logic          valid   = 1'b0;
        logic          ready_o;
        logic [DW-1:0] data_i  = '0;
        logic          stall   = 1'b0;
        logic          flush   = 1'b0;
        logic          valid_o;
        logic          ready_i = 1'b0;
        logic [DW-1:0] data_o;
        logic [1:0]    occ;
        logic [CW-1:0] xfer_cnt;
        logic [CW-1:0] kill_cnt;

        logic [DW-1:0] q[$];
        int            xfers   = 0;
        int            kills   = 0;
        bit            m_ready = 1'b0;
        bit            alive   = 1'b0;
        bit            done    = 1'b0;

        pipe_stage_reg #(
            .DW(DW), .SKID(SK), .ZERO_BUBBLE(1), .RST_VAL(BUB), .CNTW(CW)
        ) dut (
            .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(ready_o),
            .i_data(data_i), .i_stall(stall), .i_flush(flush), .o_valid(valid_o),
            .i_ready(ready_i), .o_data(data_o), .o_occ(occ),
            .o_xfer_cnt(xfer_cnt), .o_kill_cnt(kill_cnt)
        );

        // One clock of stimulus; the model decides acceptance from its own occupancy.
        task automatic cyc(input bit rst, input bit v, input logic [DW-1:0] d,
                           input bit r, input bit s, input bit f, output bit acc);
            @(negedge clk);
            rst_n = rst; valid = v; data_i = d; ready_i = r; stall = s; flush = f;
            acc = 1'b0;
            if (!rst) begin
                q.delete(); xfers = 0; kills = 0; m_ready = 1'b0;
            end else if (!alive) begin
                m_ready = 1'b0;
            end else if (SK != 0) begin
                m_ready = (q.size() < 2);
            end else begin
                m_ready = (q.size() == 0) || (r && !s);
            end
            #4;
            if (rst) begin
                if (f) begin
                    kills += q.size();
                    q.delete();
                end else if (v && m_ready) begin
                    q.push_back(d);
                    acc = 1'b1;
                end
            end
            alive = rst;
        endtask

        task automatic mid_reset();
            @(negedge clk);
            #2;
            rst_n = 1'b0; valid = 1'b0;
            q.delete(); xfers = 0; kills = 0; m_ready = 1'b0; alive = 1'b0;
        endtask

        initial begin : drv
            bit acc;
            int sent;
            cyc(0, 0, '0, 0, 0, 0, acc);
            cyc(0, 0, '0, 0, 0, 0, acc);
            cyc(1, 1, 32'h99, 1, 0, 0, acc);
            if (SK != 0) begin
                for (int i = 1; i <= 8; i++) cyc(1, 1, DW'(i), 1, 0, 0, acc);
                repeat (2) cyc(1, 0, '0, 1, 0, 0, acc);
                cyc(1, 1, 32'hA, 0, 0, 0, acc);
                cyc(1, 1, 32'hB, 0, 0, 0, acc);
                repeat (3) cyc(1, 1, 32'hEE, 0, 0, 0, acc);
                repeat (3) cyc(1, 0, '0, 1, 0, 0, acc);
                cyc(1, 1, 32'hA, 0, 0, 0, acc);
                cyc(1, 1, 32'hB, 0, 0, 0, acc);
                cyc(1, 1, 32'hC, 1, 0, 1, acc);
                repeat (2) cyc(1, 0, '0, 1, 0, 0, acc);
                cyc(1, 1, 32'h5, 0, 0, 0, acc);
                repeat (2) cyc(1, 0, '0, 1, 1, 0, acc);
                cyc(1, 0, '0, 1, 1, 1, acc);
                cyc(1, 0, '0, 1, 0, 0, acc);
                cyc(1, 1, 32'hA, 0, 0, 0, acc);
                cyc(1, 1, 32'hB, 0, 0, 0, acc);
                mid_reset();
                cyc(0, 0, '0, 1, 0, 0, acc);
                cyc(1, 1, 32'h77, 1, 0, 0, acc);
                cyc(1, 1, 32'h78, 1, 0, 0, acc);
            end else begin
                sent = 0;
                for (int k = 0; k < 200 && sent < 17; k++) begin
                    cyc(1, 1, DW'(sent + 1), (k % 2) == 1, 0, 0, acc);
                    if (acc) sent++;
                end
                repeat (3) cyc(1, 0, '0, 1, 0, 0, acc);
            end
            for (int i = 0; i < 400; i++) begin
                cyc(1, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 99) < ((SK != 0) ? 5 : 8), acc);
            end
            repeat (4) cyc(1, 0, '0, 1, 0, 0, acc);
            done = 1'b1;
        end

        initial begin : mon
            while (!done) begin
                @(negedge clk);
                #3;
                check($sformatf("L%0d.valid", g), 64'(valid_o), 64'(q.size() != 0));
                check($sformatf("L%0d.occ", g), 64'(occ), 64'(q.size()));
                check($sformatf("L%0d.ready", g), 64'(ready_o), 64'(m_ready));
                check($sformatf("L%0d.data", g), 64'(data_o), 64'((q.size() != 0) ? q[0] : BUB));
                check($sformatf("L%0d.xfer_cnt", g), 64'(xfer_cnt), 64'(xfers % (1 << CW)));
                check($sformatf("L%0d.kill_cnt", g), 64'(kill_cnt),
                      64'((kills > (1 << CW) - 1) ? (1 << CW) - 1 : kills));
                if (rst_n && valid_o && ready_i && !stall && !flush && q.size() != 0) begin
                    void'(q.pop_front());
                    xfers++;
                end
            end
        end
    end

    initial begin
        int t;
        for (t = 0; t < 50000; t++) begin
            if (lane[0].done && lane[1].done) break;
            @(posedge clk);
        end
        if (!(lane[0].done && lane[1].done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus not finished after %0d cycles, required completion", t);
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
